// File: rtl/axi_range_filter_rd.sv
// AXI4 read-channel address filter: ARs are matched against enabled address windows
// (allow- or deny-list); blocked ARs are answered locally with an error burst, in order.
module axi_range_filter_rd #(
    parameter int                          AXI_ADDR_WIDTH      = 32,
    parameter int                          AXI_DATA_WIDTH      = 64,
    parameter int                          AXI_ID_WIDTH        = 7,
    parameter int                          AXI_USER_WIDTH      = 4,
    parameter int                          NBR_RANGE           = 4,
    parameter int                          NBR_OUTSTANDING_REQ = 4,
    parameter int                          AXI_LOOK_BITS       = 4,
    parameter logic [AXI_DATA_WIDTH-1:0]   ERR_DATA            = {AXI_DATA_WIDTH/64{64'hCA11_AB1E_DEAD_BEEF}},
    parameter int                          ERR_CNT_WIDTH       = 16
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_scan_ckgt_enable,
    input  logic [NBR_RANGE*AXI_ADDR_WIDTH-1:0] i_range_start,
    input  logic [NBR_RANGE*AXI_ADDR_WIDTH-1:0] i_range_stop,
    input  logic [NBR_RANGE-1:0]                i_range_en,
    input  logic                                i_allow_mode,
    input  logic                                i_decerr,
    input  logic                                i_err_clr,
    // AR slave side
    input  logic                                axi_in_ar_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]           axi_in_ar_addr_i,
    input  logic [2:0]                          axi_in_ar_prot_i,
    input  logic [3:0]                          axi_in_ar_region_i,
    input  logic [7:0]                          axi_in_ar_len_i,
    input  logic [2:0]                          axi_in_ar_size_i,
    input  logic [1:0]                          axi_in_ar_burst_i,
    input  logic                                axi_in_ar_lock_i,
    input  logic [3:0]                          axi_in_ar_cache_i,
    input  logic [3:0]                          axi_in_ar_qos_i,
    input  logic [AXI_ID_WIDTH-1:0]             axi_in_ar_id_i,
    input  logic [AXI_USER_WIDTH-1:0]           axi_in_ar_user_i,
    output logic                                axi_in_ar_ready_o,
    // R slave side
    output logic                                axi_in_r_valid_o,
    output logic [AXI_DATA_WIDTH-1:0]           axi_in_r_data_o,
    output logic [1:0]                          axi_in_r_resp_o,
    output logic                                axi_in_r_last_o,
    output logic [AXI_ID_WIDTH-1:0]             axi_in_r_id_o,
    output logic [AXI_USER_WIDTH-1:0]           axi_in_r_user_o,
    input  logic                                axi_in_r_ready_i,
    // AR master side
    output logic                                axi_out_ar_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0]           axi_out_ar_addr_o,
    output logic [2:0]                          axi_out_ar_prot_o,
    output logic [3:0]                          axi_out_ar_region_o,
    output logic [7:0]                          axi_out_ar_len_o,
    output logic [2:0]                          axi_out_ar_size_o,
    output logic [1:0]                          axi_out_ar_burst_o,
    output logic                                axi_out_ar_lock_o,
    output logic [3:0]                          axi_out_ar_cache_o,
    output logic [3:0]                          axi_out_ar_qos_o,
    output logic [AXI_ID_WIDTH-1:0]             axi_out_ar_id_o,
    output logic [AXI_USER_WIDTH-1:0]           axi_out_ar_user_o,
    input  logic                                axi_out_ar_ready_i,
    // R master side
    input  logic                                axi_out_r_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0]           axi_out_r_data_i,
    input  logic [1:0]                          axi_out_r_resp_i,
    input  logic                                axi_out_r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]             axi_out_r_id_i,
    input  logic [AXI_USER_WIDTH-1:0]           axi_out_r_user_i,
    output logic                                axi_out_r_ready_o,
    // fault capture
    output logic                                o_err_valid,
    output logic [AXI_ADDR_WIDTH-1:0]           o_err_addr,
    output logic [AXI_ID_WIDTH-1:0]             o_err_id,
    output logic [ERR_CNT_WIDTH-1:0]            o_err_cnt,
    output logic                                o_err_irq,
    output logic                                o_dbg_r_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // valid never waits on ready, and once raised the payload is held until that edge.

    localparam int DEPTH      = NBR_OUTSTANDING_REQ;
    localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W      = $clog2(DEPTH + 1);
    localparam int NBR_ID_CNT = 2 ** AXI_LOOK_BITS;
    localparam int ENTRY_W    = 1 + AXI_ID_WIDTH + AXI_USER_WIDTH + 8;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef enum logic {R_IDLE = 1'b0, R_ERROR = 1'b1} r_state_e;

    r_state_e                  state_q, state_d;
    logic [7:0]                beat_cnt_q, beat_cnt_d;
    logic [ENTRY_W-1:0]        fifo_mem_q [DEPTH];
    logic [ENTRY_W-1:0]        fifo_mem_d [DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]          id_cnt_q [NBR_ID_CNT];
    logic [CNT_W-1:0]          id_cnt_d [NBR_ID_CNT];
    logic                      err_valid_q, err_valid_d;
    logic [AXI_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [AXI_ID_WIDTH-1:0]   err_id_q, err_id_d;
    logic [ERR_CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic                      err_irq_q, err_irq_d;

    logic [NBR_RANGE-1:0]      win_hit;
    logic                      ar_blocked, can_accept, fifo_push, fifo_pop;
    logic                      fifo_full, fifo_empty, err_event;
    logic [AXI_LOOK_BITS-1:0]  ar_look, head_look;
    logic [ENTRY_W-1:0]        head;
    logic                      head_blocked;
    logic [AXI_ID_WIDTH-1:0]   head_id;
    logic [AXI_USER_WIDTH-1:0] head_user;
    logic [7:0]                head_len;
    logic                      unused_scan;

    assign unused_scan = i_scan_ckgt_enable;

    always_comb begin
        for (int i = 0; i < NBR_RANGE; i++) begin
            win_hit[i] = i_range_en[i]
                && (axi_in_ar_addr_i >= i_range_start[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH])
                && (axi_in_ar_addr_i <= i_range_stop[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]);
        end
    end

    assign ar_blocked = i_allow_mode ? !(|win_hit) : (|win_hit);

    assign fifo_full    = (fifo_cnt_q == CNT_MAX);
    assign fifo_empty   = (fifo_cnt_q == '0);
    assign head         = fifo_mem_q[rd_ptr_q];
    assign head_len     = head[7:0];
    assign head_user    = head[8 +: AXI_USER_WIDTH];
    assign head_id      = head[8+AXI_USER_WIDTH +: AXI_ID_WIDTH];
    assign head_blocked = head[ENTRY_W-1];
    assign ar_look      = axi_in_ar_id_i[AXI_LOOK_BITS-1:0];
    assign head_look    = head_id[AXI_LOOK_BITS-1:0];

    // Reset gates the AR handshake so nothing is accepted while the block is held in reset.
    assign can_accept         = i_rst_n && !fifo_full && (id_cnt_q[ar_look] != CNT_MAX);
    assign axi_in_ar_ready_o  = can_accept && (ar_blocked || axi_out_ar_ready_i);
    assign axi_out_ar_valid_o = axi_in_ar_valid_i && can_accept && !ar_blocked;
    assign fifo_push          = axi_in_ar_valid_i && axi_in_ar_ready_o;
    assign err_event          = fifo_push && ar_blocked;

    assign axi_out_ar_addr_o   = axi_in_ar_addr_i;
    assign axi_out_ar_prot_o   = axi_in_ar_prot_i;
    assign axi_out_ar_region_o = axi_in_ar_region_i;
    assign axi_out_ar_len_o    = axi_in_ar_len_i;
    assign axi_out_ar_size_o   = axi_in_ar_size_i;
    assign axi_out_ar_burst_o  = axi_in_ar_burst_i;
    assign axi_out_ar_lock_o   = axi_in_ar_lock_i;
    assign axi_out_ar_cache_o  = axi_in_ar_cache_i;
    assign axi_out_ar_qos_o    = axi_in_ar_qos_i;
    assign axi_out_ar_id_o     = axi_in_ar_id_i;
    assign axi_out_ar_user_o   = axi_in_ar_user_i;

    // Order FIFO
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (fifo_push) begin
            fifo_mem_d[wr_ptr_q] = {ar_blocked, axi_in_ar_id_i, axi_in_ar_user_i, axi_in_ar_len_i};
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (fifo_push && !fifo_pop) begin
            fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        end else if (fifo_pop && !fifo_push) begin
            fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
        end
    end

    // Per-ID outstanding counters; pops are charged to the FIFO-head ID.
    always_comb begin
        id_cnt_d = id_cnt_q;
        if (fifo_push && !(fifo_pop && (head_look == ar_look))) begin
            id_cnt_d[ar_look] = id_cnt_q[ar_look] + CNT_W'(1);
        end
        if (fifo_pop && !(fifo_push && (head_look == ar_look))) begin
            id_cnt_d[head_look] = id_cnt_q[head_look] - CNT_W'(1);
        end
    end

    // R FSM
    always_comb begin
        state_d           = state_q;
        beat_cnt_d        = beat_cnt_q;
        fifo_pop          = 1'b0;
        axi_in_r_valid_o  = 1'b0;
        axi_in_r_data_o   = '0;
        axi_in_r_resp_o   = 2'b00;
        axi_in_r_last_o   = 1'b0;
        axi_in_r_id_o     = '0;
        axi_in_r_user_o   = '0;
        axi_out_r_ready_o = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (!fifo_empty) begin
                    if (!head_blocked) begin
                        axi_in_r_valid_o  = axi_out_r_valid_i;
                        axi_in_r_data_o   = axi_out_r_data_i;
                        axi_in_r_resp_o   = axi_out_r_resp_i;
                        axi_in_r_last_o   = axi_out_r_last_i;
                        axi_in_r_id_o     = axi_out_r_id_i;
                        axi_in_r_user_o   = axi_out_r_user_i;
                        axi_out_r_ready_o = axi_in_r_ready_i;
                        fifo_pop = axi_out_r_valid_i && axi_in_r_ready_i && axi_out_r_last_i;
                    end else begin
                        beat_cnt_d = head_len;
                        state_d    = R_ERROR;
                    end
                end
            end
            R_ERROR: begin
                axi_in_r_valid_o = 1'b1;
                axi_in_r_data_o  = ERR_DATA;
                axi_in_r_resp_o  = i_decerr ? 2'b11 : 2'b10;
                axi_in_r_last_o  = (beat_cnt_q == 8'd0);
                axi_in_r_id_o    = head_id;
                axi_in_r_user_o  = head_user;
                if (axi_in_r_ready_i) begin
                    if (beat_cnt_q == 8'd0) begin
                        fifo_pop = 1'b1;
                        state_d  = R_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    // Fault capture: a clear in the same cycle as a blocked AR is applied first.
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        err_id_d    = err_id_q;
        err_cnt_d   = err_cnt_q;
        err_irq_d   = err_event;
        if (i_err_clr) begin
            err_valid_d = 1'b0;
            err_addr_d  = '0;
            err_id_d    = '0;
            err_cnt_d   = '0;
        end
        if (err_event) begin
            if (!err_valid_d) begin
                err_valid_d = 1'b1;
                err_addr_d  = axi_in_ar_addr_i;
                err_id_d    = axi_in_ar_id_i;
            end
            if (err_cnt_d != '1) begin
                err_cnt_d = err_cnt_d + ERR_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= R_IDLE;
            beat_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_id_q    <= '0;
            err_cnt_q   <= '0;
            err_irq_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) fifo_mem_q[i] <= '0;
            for (int i = 0; i < NBR_ID_CNT; i++) id_cnt_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_id_q    <= err_id_d;
            err_cnt_q   <= err_cnt_d;
            err_irq_q   <= err_irq_d;
            fifo_mem_q  <= fifo_mem_d;
            id_cnt_q    <= id_cnt_d;
        end
    end

    assign o_err_valid   = err_valid_q;
    assign o_err_addr    = err_addr_q;
    assign o_err_id      = err_id_q;
    assign o_err_cnt     = err_cnt_q;
    assign o_err_irq     = err_irq_q;
    assign o_dbg_r_state = (state_q == R_ERROR);

endmodule

// File: tb/tb_axi_range_filter_rd.sv
// Directed bench for axi_range_filter_rd: deny/allow filtering, ordering, stalls,
// long error bursts, fault capture and reset abort.
module tb_axi_range_filter_rd;

    localparam logic [63:0] ERR = 64'hCA11_AB1E_DEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         scan = 1'b0;
    logic [127:0] range_start = '0, range_stop = '0;
    logic [3:0]   range_en = '0;
    logic         allow_mode = 1'b0, decerr = 1'b0, err_clr = 1'b0;

    logic         in_ar_valid = 1'b0;
    logic [31:0]  in_ar_addr = '0;
    logic [7:0]   in_ar_len = '0;
    logic [6:0]   in_ar_id = '0;
    logic         in_ar_ready;
    logic         in_r_valid, in_r_last;
    logic [63:0]  in_r_data;
    logic [1:0]   in_r_resp;
    logic [6:0]   in_r_id;
    logic [3:0]   in_r_user;
    logic         in_r_ready = 1'b1;

    logic         out_ar_valid, out_ar_lock;
    logic [31:0]  out_ar_addr;
    logic [2:0]   out_ar_prot, out_ar_size;
    logic [3:0]   out_ar_region, out_ar_cache, out_ar_qos, out_ar_user;
    logic [7:0]   out_ar_len;
    logic [1:0]   out_ar_burst;
    logic [6:0]   out_ar_id;
    logic         out_ar_ready = 1'b1;

    logic         out_r_valid = 1'b0, out_r_last = 1'b0;
    logic [63:0]  out_r_data = '0;
    logic [6:0]   out_r_id = '0;
    logic         out_r_ready;

    logic         err_valid, err_irq, dbg_state;
    logic [31:0]  err_addr;
    logic [6:0]   err_id;
    logic [7:0]   err_cnt;

    int vec_cnt = 0;
    int err_cnt_tb = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    axi_range_filter_rd #(.ERR_CNT_WIDTH(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_scan_ckgt_enable(scan),
        .i_range_start(range_start), .i_range_stop(range_stop), .i_range_en(range_en),
        .i_allow_mode(allow_mode), .i_decerr(decerr), .i_err_clr(err_clr),
        .axi_in_ar_valid_i(in_ar_valid), .axi_in_ar_addr_i(in_ar_addr), .axi_in_ar_prot_i(3'd0),
        .axi_in_ar_region_i(4'd0), .axi_in_ar_len_i(in_ar_len), .axi_in_ar_size_i(3'd3),
        .axi_in_ar_burst_i(2'b01), .axi_in_ar_lock_i(1'b0), .axi_in_ar_cache_i(4'd0),
        .axi_in_ar_qos_i(4'd0), .axi_in_ar_id_i(in_ar_id), .axi_in_ar_user_i(4'hA),
        .axi_in_ar_ready_o(in_ar_ready),
        .axi_in_r_valid_o(in_r_valid), .axi_in_r_data_o(in_r_data), .axi_in_r_resp_o(in_r_resp),
        .axi_in_r_last_o(in_r_last), .axi_in_r_id_o(in_r_id), .axi_in_r_user_o(in_r_user),
        .axi_in_r_ready_i(in_r_ready),
        .axi_out_ar_valid_o(out_ar_valid), .axi_out_ar_addr_o(out_ar_addr), .axi_out_ar_prot_o(out_ar_prot),
        .axi_out_ar_region_o(out_ar_region), .axi_out_ar_len_o(out_ar_len), .axi_out_ar_size_o(out_ar_size),
        .axi_out_ar_burst_o(out_ar_burst), .axi_out_ar_lock_o(out_ar_lock), .axi_out_ar_cache_o(out_ar_cache),
        .axi_out_ar_qos_o(out_ar_qos), .axi_out_ar_id_o(out_ar_id), .axi_out_ar_user_o(out_ar_user),
        .axi_out_ar_ready_i(out_ar_ready),
        .axi_out_r_valid_i(out_r_valid), .axi_out_r_data_i(out_r_data), .axi_out_r_resp_i(2'b00),
        .axi_out_r_last_i(out_r_last), .axi_out_r_id_i(out_r_id), .axi_out_r_user_i(4'h5),
        .axi_out_r_ready_o(out_r_ready),
        .o_err_valid(err_valid), .o_err_addr(err_addr), .o_err_id(err_id), .o_err_cnt(err_cnt),
        .o_err_irq(err_irq), .o_dbg_r_state(dbg_state)
    );

    // Drivers: all are entered and left 1 time unit after a rising edge.
    task automatic ar_drive(input logic [31:0] addr, input logic [7:0] len, input logic [6:0] id,
                            output logic acc, output logic saw_out, output logic [31:0] out_addr);
        in_ar_valid = 1'b1; in_ar_addr = addr; in_ar_len = len; in_ar_id = id;
        acc = 1'b0; saw_out = 1'b0; out_addr = '0;
        #1;
        for (int k = 0; k < 64; k++) begin
            if (out_ar_valid) begin saw_out = 1'b1; out_addr = out_ar_addr; end
            if (in_ar_ready) begin acc = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_ar_valid = 1'b0;
    endtask

    task automatic r_wait_beat(output logic got, output logic [63:0] d, output logic [1:0] rs,
                               output logic l, output logic [6:0] id);
        got = 1'b0; d = '0; rs = '0; l = 1'b0; id = '0;
        for (int k = 0; k < 64; k++) begin
            if (in_r_valid && in_r_ready) begin
                got = 1'b1; d = in_r_data; rs = in_r_resp; l = in_r_last; id = in_r_id;
            end
            @(posedge clk); #1;
            if (got) break;
        end
    endtask

    task automatic slave_beat(input logic [63:0] data, input logic [6:0] id, input logic last,
                              output logic fv, output logic [63:0] fd, output logic fl, output logic dr);
        out_r_valid = 1'b1; out_r_data = data; out_r_id = id; out_r_last = last;
        #1;
        fv = in_r_valid; fd = in_r_data; fl = in_r_last; dr = out_r_ready;
        @(posedge clk); #1;
        out_r_valid = 1'b0; out_r_last = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        vec_cnt++;
        if ({in_r_valid, out_r_ready, out_ar_valid, in_ar_ready, err_valid, err_irq} !== 6'b0 ||
            err_cnt !== 8'd0 || err_addr !== 32'd0 || err_id !== 7'd0) begin
            err_cnt_tb++;
            $display("FAIL reset_outputs: got flags %b cnt %h addr %h id %h, expected all zero",
                     {in_r_valid, out_r_ready, out_ar_valid, in_ar_ready, err_valid, err_irq}, err_cnt, err_addr, err_id);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vec_cnt++;
        if (in_r_valid !== 1'b0 || dbg_state !== 1'b0) begin
            err_cnt_tb++; $display("FAIL post_reset_idle: got valid %b state %b expected 0 0", in_r_valid, dbg_state);
        end
    endtask

    task automatic test_deny_block;
        logic acc, so, got, l; logic [31:0] oa; logic [63:0] d; logic [1:0] rs; logic [6:0] id;
        allow_mode = 1'b0; decerr = 1'b0;
        range_start[31:0] = 32'h1000; range_stop[31:0] = 32'h1FFF; range_en = 4'b0001;
        ar_drive(32'h1800, 8'd3, 7'd5, acc, so, oa);
        vec_cnt++; if (acc !== 1'b1 || so !== 1'b0) begin err_cnt_tb++; $display("FAIL deny_ar: got acc %b out_valid %b expected 1 0", acc, so); end
        vec_cnt++; if (err_irq !== 1'b1) begin err_cnt_tb++; $display("FAIL deny_irq_high: got %b expected 1", err_irq); end
        vec_cnt++; if (err_valid !== 1'b1 || err_addr !== 32'h1800 || err_id !== 7'd5 || err_cnt !== 8'd1) begin
            err_cnt_tb++; $display("FAIL deny_capture: got v %b addr %h id %0d cnt %0d expected 1 1800 5 1", err_valid, err_addr, err_id, err_cnt);
        end
        @(posedge clk); #1;
        vec_cnt++; if (err_irq !== 1'b0 || dbg_state !== 1'b1) begin
            err_cnt_tb++; $display("FAIL deny_irq_pulse: got irq %b state %b expected 0 1", err_irq, dbg_state);
        end
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back(ERR);
            r_wait_beat(got, d, rs, l, id);
            vec_cnt++;
            if (got !== 1'b1 || d !== exp_q.pop_front() || rs !== 2'b10 || l !== (b == 3) || id !== 7'd5) begin
                err_cnt_tb++; $display("FAIL deny_beat%0d: got v %b data %h resp %b last %b id %0d expected 1 %h 10 %b 5", b, got, d, rs, l, id, ERR, (b == 3));
            end
        end
        vec_cnt++; if (in_r_valid !== 1'b0) begin err_cnt_tb++; $display("FAIL deny_no_extra: got valid %b expected 0", in_r_valid); end
    endtask

    task automatic test_allow_order;
        logic acc, so, got, l, fv, fl, dr; logic [31:0] oa; logic [63:0] d, fd; logic [1:0] rs; logic [6:0] id;
        allow_mode = 1'b1; decerr = 1'b1;
        ar_drive(32'h1800, 8'd1, 7'd2, acc, so, oa);
        vec_cnt++; if (acc !== 1'b1 || so !== 1'b1 || oa !== 32'h1800 || err_irq !== 1'b0) begin
            err_cnt_tb++; $display("FAIL allow_pass_ar: got acc %b out %b addr %h irq %b expected 1 1 1800 0", acc, so, oa, err_irq);
        end
        ar_drive(32'h3000, 8'd0, 7'd3, acc, so, oa);
        vec_cnt++; if (acc !== 1'b1 || so !== 1'b0) begin err_cnt_tb++; $display("FAIL allow_block_ar: got acc %b out %b expected 1 0", acc, so); end
        vec_cnt++; if (in_r_valid !== 1'b0 || out_r_ready !== 1'b1) begin
            err_cnt_tb++; $display("FAIL allow_wait_pass: got valid %b dn_ready %b expected 0 1", in_r_valid, out_r_ready);
        end
        exp_q.push_back(64'h1111_0000_0000_0001);
        exp_q.push_back(64'h2222_0000_0000_0002);
        exp_q.push_back(ERR);
        slave_beat(64'h1111_0000_0000_0001, 7'd2, 1'b0, fv, fd, fl, dr);
        vec_cnt++; if (fv !== 1'b1 || fd !== exp_q.pop_front() || fl !== 1'b0) begin
            err_cnt_tb++; $display("FAIL allow_fwd0: got v %b data %h last %b expected 1 1111000000000001 0", fv, fd, fl);
        end
        slave_beat(64'h2222_0000_0000_0002, 7'd2, 1'b1, fv, fd, fl, dr);
        vec_cnt++; if (fv !== 1'b1 || fd !== exp_q.pop_front() || fl !== 1'b1) begin
            err_cnt_tb++; $display("FAIL allow_fwd1: got v %b data %h last %b expected 1 2222000000000002 1", fv, fd, fl);
        end
        vec_cnt++; if (in_r_valid !== 1'b0) begin err_cnt_tb++; $display("FAIL allow_err_early: got valid %b expected 0", in_r_valid); end
        r_wait_beat(got, d, rs, l, id);
        vec_cnt++; if (got !== 1'b1 || d !== exp_q.pop_front() || rs !== 2'b11 || l !== 1'b1 || id !== 7'd3) begin
            err_cnt_tb++; $display("FAIL allow_err_beat: got v %b data %h resp %b last %b id %0d expected 1 %h 11 1 3", got, d, rs, l, id, ERR);
        end
        range_en = 4'b0000;
        ar_drive(32'h1800, 8'd0, 7'd1, acc, so, oa);
        vec_cnt++; if (acc !== 1'b1 || so !== 1'b0) begin err_cnt_tb++; $display("FAIL allow_none_enabled: got acc %b out %b expected 1 0", acc, so); end
        r_wait_beat(got, d, rs, l, id);
        vec_cnt++; if (got !== 1'b1 || rs !== 2'b11 || id !== 7'd1 || l !== 1'b1) begin
            err_cnt_tb++; $display("FAIL allow_none_beat: got v %b resp %b id %0d last %b expected 1 11 1 1", got, rs, id, l);
        end
        range_en = 4'b0001;
    endtask

    task automatic test_outstanding;
        logic acc, so, fv, fl, dr; logic [31:0] oa; logic [63:0] fd; int ok, leak;
        allow_mode = 1'b0; decerr = 1'b0; ok = 0; leak = 0;
        for (int n = 0; n < 4; n++) begin
            ar_drive(32'h5000, 8'd0, 7'd7, acc, so, oa);
            if (acc && so) ok++;
        end
        vec_cnt++; if (ok !== 4) begin err_cnt_tb++; $display("FAIL out_accept4: got %0d accepted expected 4", ok); end
        in_ar_valid = 1'b1; in_ar_addr = 32'h5000; in_ar_len = 8'd0; in_ar_id = 7'd7;
        #1;
        for (int c = 0; c < 3; c++) begin
            if (in_ar_ready || out_ar_valid) leak++;
            @(posedge clk); #1;
        end
        vec_cnt++; if (leak !== 0) begin err_cnt_tb++; $display("FAIL out_stall5: got %0d cycles with handshake expected 0", leak); end
        slave_beat(64'h77, 7'd7, 1'b1, fv, fd, fl, dr);
        vec_cnt++; if (in_ar_ready !== 1'b1 || fv !== 1'b1) begin
            err_cnt_tb++; $display("FAIL out_release: got ready %b fwd %b expected 1 1", in_ar_ready, fv);
        end
        @(posedge clk); #1;
        in_ar_valid = 1'b0;
        ok = 0;
        for (int n = 0; n < 4; n++) begin
            slave_beat(64'h80 + 64'(n), 7'd7, 1'b1, fv, fd, fl, dr);
            if (fv && fl && dr) ok++;
        end
        vec_cnt++; if (ok !== 4) begin err_cnt_tb++; $display("FAIL out_drain: got %0d bursts expected 4", ok); end
        vec_cnt++; if (out_r_ready !== 1'b0 || in_r_valid !== 1'b0) begin
            err_cnt_tb++; $display("FAIL out_empty: got dn_ready %b valid %b expected 0 0", out_r_ready, in_r_valid);
        end
    endtask

    task automatic test_long_burst;
        logic acc, so; logic [31:0] oa; int beats, lasts, bad; logic done;
        decerr = 1'b0; beats = 0; lasts = 0; bad = 0; done = 1'b0;
        ar_drive(32'h1004, 8'd255, 7'd9, acc, so, oa);
        for (int c = 0; c < 1200 && !done; c++) begin
            in_r_ready = c[0];
            #1;
            if (in_r_valid && in_r_ready) begin
                beats++;
                if (in_r_data !== ERR || in_r_resp !== 2'b10 || in_r_id !== 7'd9) bad++;
                if (in_r_last) begin lasts++; done = 1'b1; end
            end
            @(posedge clk); #1;
        end
        in_r_ready = 1'b1;
        vec_cnt++; if (beats !== 256 || lasts !== 1 || bad !== 0) begin
            err_cnt_tb++; $display("FAIL long_burst: got beats %0d lasts %0d bad %0d expected 256 1 0", beats, lasts, bad);
        end
        @(posedge clk); #1;
        vec_cnt++; if (in_r_valid !== 1'b0 || dbg_state !== 1'b0) begin
            err_cnt_tb++; $display("FAIL long_pop_once: got valid %b state %b expected 0 0", in_r_valid, dbg_state);
        end
    endtask

    task automatic test_err_clr_sat;
        logic acc, so, got, l; logic [31:0] oa; logic [63:0] d; logic [1:0] rs; logic [6:0] id; int miss;
        miss = 0;
        err_clr = 1'b1;
        ar_drive(32'h1A00, 8'd0, 7'd4, acc, so, oa);
        err_clr = 1'b0;
        vec_cnt++; if (err_valid !== 1'b1 || err_cnt !== 8'd1 || err_addr !== 32'h1A00 || err_id !== 7'd4 || err_irq !== 1'b1) begin
            err_cnt_tb++; $display("FAIL clr_same_cycle: got v %b cnt %0d addr %h id %0d irq %b expected 1 1 1a00 4 1", err_valid, err_cnt, err_addr, err_id, err_irq);
        end
        r_wait_beat(got, d, rs, l, id);
        for (int n = 0; n < 300; n++) begin
            ar_drive(32'h1000 + 32'(n * 4), 8'd0, 7'(n), acc, so, oa);
            if (!acc || so) miss++;
        end
        vec_cnt++; if (miss !== 0) begin err_cnt_tb++; $display("FAIL sat_accepts: got %0d bad ARs expected 0", miss); end
        vec_cnt++; if (err_cnt !== 8'hFF || err_addr !== 32'h1A00 || err_id !== 7'd4) begin
            err_cnt_tb++; $display("FAIL sat_count: got cnt %h addr %h id %0d expected ff 1a00 4", err_cnt, err_addr, err_id);
        end
        repeat (12) @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        vec_cnt++; if (err_valid !== 1'b0 || err_cnt !== 8'd0 || err_addr !== 32'd0 || err_id !== 7'd0) begin
            err_cnt_tb++; $display("FAIL clr_alone: got v %b cnt %0d addr %h id %0d expected all zero", err_valid, err_cnt, err_addr, err_id);
        end
    endtask

    task automatic test_reset_mid_burst;
        logic acc, so, got, l; logic [31:0] oa; logic [63:0] d; logic [1:0] rs; logic [6:0] id; int stale;
        stale = 0;
        ar_drive(32'h1100, 8'd15, 7'd1, acc, so, oa);
        for (int b = 0; b < 3; b++) r_wait_beat(got, d, rs, l, id);
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (in_r_valid !== 1'b0 || dbg_state !== 1'b0 || err_valid !== 1'b0 || err_cnt !== 8'd0 || in_ar_ready !== 1'b0) begin
            err_cnt_tb++; $display("FAIL rst_async: got valid %b state %b errv %b cnt %0d ready %b expected all 0", in_r_valid, dbg_state, err_valid, err_cnt, in_ar_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (in_r_valid) stale++;
            @(posedge clk); #1;
        end
        vec_cnt++; if (stale !== 0) begin err_cnt_tb++; $display("FAIL rst_stale: got %0d stale beats expected 0", stale); end
        ar_drive(32'h1200, 8'd1, 7'd6, acc, so, oa);
        for (int b = 0; b < 2; b++) begin
            r_wait_beat(got, d, rs, l, id);
            vec_cnt++;
            if (got !== 1'b1 || id !== 7'd6 || l !== (b == 1) || d !== ERR) begin
                err_cnt_tb++; $display("FAIL rst_new_beat%0d: got v %b id %0d last %b data %h expected 1 6 %b %h", b, got, id, l, d, (b == 1), ERR);
            end
        end
        vec_cnt++; if (in_r_valid !== 1'b0) begin err_cnt_tb++; $display("FAIL rst_new_end: got valid %b expected 0", in_r_valid); end
    endtask

    initial begin
        test_reset();
        test_deny_block();
        test_allow_order();
        test_outstanding();
        test_long_burst();
        test_err_clr_sat();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt_tb);
        $finish;
    end

endmodule

// File: doc/axi_range_filter_rd.md
Name: axi_range_filter_rd

Overview:
Second-generation AXI4 read-channel address filter. It sits between an AXI read master and the interconnect. Each AR is checked against NBR_RANGE individually enabled address windows, interpreted as an allow-list or a deny-list. Permitted requests pass through; blocked requests are absorbed locally and answered with a full-length error burst, in request order. Adds per-ID outstanding counters, a selectable SLVERR/DECERR response, a parametrised error data pattern, and fault capture/interrupt.

Parameters:
AXI_ADDR_WIDTH, 32, address width
AXI_DATA_WIDTH, 64, data width
AXI_ID_WIDTH, 7, ID width
AXI_USER_WIDTH, 4, user width
NBR_RANGE, 4, number of address windows
NBR_OUTSTANDING_REQ, 4, order-FIFO depth (max in-flight ARs, passed plus blocked)
AXI_LOOK_BITS, 4, low ID bits indexing the per-ID counters (2**AXI_LOOK_BITS counters)
ERR_DATA, {AXI_DATA_WIDTH/64{64'hCA11_AB1E_DEAD_BEEF}}, R data driven on error beats
ERR_CNT_WIDTH, 16, width of the blocked-request counter

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_scan_ckgt_enable  in  1  FIFO testmode
i_range_start  in  NBR_RANGE x AXI_ADDR_WIDTH  window start, inclusive
i_range_stop  in  NBR_RANGE x AXI_ADDR_WIDTH  window stop, inclusive
i_range_en  in  NBR_RANGE  per-window enable
i_allow_mode  in  1  1: windows are an allow-list; 0: windows are a deny-list
i_decerr  in  1  1: error resp 2'b11; 0: error resp 2'b10
i_err_clr  in  1  clears o_err_valid, o_err_addr, o_err_id and o_err_cnt
axi_in_ar_*  in/out  AXI4 AR slave bundle: valid, addr, prot, region, len, size, burst, lock, cache, qos, id, user in; ready out
axi_in_r_*  out/in  AXI4 R slave bundle: valid, data, resp, last, id, user out; ready in
axi_out_ar_*  out/in  AXI4 AR master bundle, mirror of axi_in_ar_*
axi_out_r_*  in/out  AXI4 R master bundle, mirror of axi_in_r_*
o_err_valid  out  1  sticky flag: a blocked AR has been captured
o_err_addr  out  AXI_ADDR_WIDTH  address of the first blocked AR since the last clear
o_err_id  out  AXI_ID_WIDTH  ID of the first blocked AR since the last clear
o_err_cnt  out  ERR_CNT_WIDTH  count of blocked ARs, saturating
o_err_irq  out  1  one-cycle pulse on every blocked-AR acceptance

Behaviour:
- hit = |(i_range_en & ((addr >= start) & (addr <= stop))), evaluated per window.
- blocked = i_allow_mode ? !hit : hit. With all windows disabled in allow mode, every AR is blocked.
- AR acceptance requires axi_in_ar_valid_i, FIFO not full, and the selected ID counter cnt[id[AXI_LOOK_BITS-1:0]] not saturated at NBR_OUTSTANDING_REQ.
  - Blocked AR: axi_in_ar_ready_o = 1 and axi_out_ar_valid_o = 0.
  - Passed AR: axi_out_ar_valid_o = 1 and axi_in_ar_ready_o = axi_out_ar_ready_i. Zero-cycle combinational path.
  - Push {blocked, id, user, len} into the order FIFO (non fall-through) on acceptance.
- AR payload fields pass through combinationally at all times. Once asserted, axi_out_ar_valid_o holds until handshake, as long as the master holds its request stable.
- The per-ID counter increments on push and decrements on pop, indexed by the FIFO-head ID (not the R bus ID). Simultaneous push and pop on the same ID: no change.
- R FSM, states IDLE and ERROR:
  - IDLE, FIFO empty: axi_in_r_valid_o = 0 and axi_out_r_ready_o = 0.
  - IDLE, head passed: R bundle forwarded combinationally (valid/ready cross-connected). Pop on a beat with last & valid & ready.
  - IDLE, head blocked: load beat counter = len and go to ERROR. The first error beat appears the next cycle.
  - ERROR: valid = 1, data = ERR_DATA, resp = i_decerr ? 2'b11 : 2'b10, id/user from the FIFO head, last = (counter == 0). axi_out_r_ready_o = 0.
  - ERROR, on ready: counter decrements. On the beat with last = 1, pop and return to IDLE.
  - An error burst is exactly len+1 beats; len = 255 gives 256 beats.
- Responses leave strictly in AR acceptance order. The downstream slave must return passed bursts in issue order.
- Fault capture:
  - On blocked acceptance with o_err_valid = 0: latch addr and id, set o_err_valid.
  - o_err_cnt increments on every blocked acceptance and saturates at all-ones.
  - o_err_irq pulses for one cycle on every blocked acceptance.
  - i_err_clr in the same cycle as a blocked acceptance: the clear applies first, the new event is then captured, and the count becomes 1.
- Reset: FSM to IDLE, FIFO empty, counters 0. All valids/readies, o_err_valid, o_err_irq, o_err_addr, o_err_id and o_err_cnt are 0. A reset mid-burst aborts it with no further beats.
- The range, mode and i_decerr inputs are quasi-static; they are sampled only at AR acceptance or on the live error beat.

Test Plan:
- Deny mode, window0 = 0x1000-0x1FFF enabled, AR addr 0x1800 len 3 id 5 -> no axi_out_ar_valid_o; 4 beats of ERR_DATA, resp 2'b10, last on beat 4, id 5; o_err_addr = 0x1800, o_err_cnt = 1, one o_err_irq pulse.
- Allow mode, same window, AR 0x1800 then 0x3000 (i_decerr = 1) -> first forwarded and its R burst passed through; second answered with resp 2'b11, strictly after the first's last beat.
- Five ARs with the same ID, NBR_OUTSTANDING_REQ = 4, no R returned -> fifth AR stalled (ready = 0) until one burst completes.
- Error burst len 255 with axi_in_r_ready_i toggling every cycle -> exactly 256 beats, last only on the final beat, FIFO popped once.
- i_err_clr asserted in the same cycle as a blocked AR -> o_err_valid = 1, o_err_cnt = 1, new address captured. Then 70000 blocked ARs -> o_err_cnt saturates at 0xFFFF.
- Reset asserted mid error burst -> outputs 0 asynchronously; after release, a new AR is handled normally with no stale beats.
